// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
//   Shared constants for the stream_mux family.
//   ARQUITECTURE_BITS : default datapath word width
//   MODE_SELECT       : output channel chosen by an explicit selector
//   MODE_RR           : output channel chosen by round-robin arbitration
package stream_mux_pkg;

  localparam int ARQUITECTURE_BITS = 32;

  localparam int MODE_SELECT = 0;
  localparam int MODE_RR     = 1;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Searches the request vector starting
//   at ptr_i and wrapping modulo CHANNELS; the first requester found wins.
//   Ports:
//     req_i       : per-channel request (in_valid)
//     ptr_i       : channel index with highest priority this cycle
//     grant_o     : one-hot grant, all zero when nobody requests
//     grant_idx_o : index of the granted channel (0 when no grant)
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_BITS = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_BITS-1:0] ptr_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [SEL_BITS-1:0] grant_idx_o
);

  // One extra bit so ptr + offset cannot overflow when CHANNELS = 2**SEL_BITS.
  localparam logic [SEL_BITS:0] CH_W = (SEL_BITS + 1)'(CHANNELS);

  // cand[k] is the channel examined at search position k.
  logic [SEL_BITS-1:0] cand [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cand
      logic [SEL_BITS:0] sum;
      logic [SEL_BITS:0] wrapped;
      assign sum     = {1'b0, ptr_i} + (SEL_BITS + 1)'(gi);
      assign wrapped = (sum >= CH_W) ? (sum - CH_W) : sum;
      assign cand[gi] = wrapped[SEL_BITS-1:0];
    end
  endgenerate

  always_comb begin
    logic found;
    found       = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!found && req_i[cand[k]]) begin
        found       = 1'b1;
        grant_idx_o = cand[k];
      end
    end
    if (found) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux
//   N-channel registered multiplexer with valid/ready handshake. One input
//   channel is chosen per cycle (explicit selector or round-robin) and its
//   word is captured into a single-entry output register.
//   Ports:
//     clk         : clock, rising edge
//     reset       : synchronous, active-low
//     selector    : channel index (MODE_SELECT only)
//     in_valid    : per-channel valid
//     in_data     : packed words, channel i at [BUS_SIZE*i +: BUS_SIZE]
//     in_ready    : per-channel ready, at most one bit set
//     out_valid   : output register holds a word
//     out_data    : registered word
//     out_channel : channel that produced out_data
//     out_ready   : consumer accepts out_data this cycle
//     sel_error   : one-cycle pulse for an out-of-range selector at load time
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int BUS_SIZE = ARQUITECTURE_BITS,
  parameter  int MODE     = MODE_SELECT,
  localparam int SEL_BITS = $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SEL_BITS-1:0]          selector,
  input  logic [CHANNELS-1:0]          in_valid,
  input  logic [CHANNELS*BUS_SIZE-1:0] in_data,
  output logic [CHANNELS-1:0]          in_ready,
  output logic                         out_valid,
  output logic [BUS_SIZE-1:0]          out_data,
  output logic [SEL_BITS-1:0]          out_channel,
  input  logic                         out_ready,
  output logic                         sel_error
);

  localparam logic [SEL_BITS:0] CH_W = (SEL_BITS + 1)'(CHANNELS);

  logic                out_valid_q,   out_valid_d;
  logic [BUS_SIZE-1:0] out_data_q,    out_data_d;
  logic [SEL_BITS-1:0] out_channel_q, out_channel_d;
  logic                sel_error_q,   sel_error_d;
  logic [SEL_BITS-1:0] ptr_q,         ptr_d;

  logic                load_en;
  logic                transfer;
  logic                sel_oob;
  logic [CHANNELS-1:0] pick_oh;
  logic [SEL_BITS-1:0] pick_idx;
  logic [BUS_SIZE-1:0] pick_word;
  logic [SEL_BITS:0]   ptr_inc;
  logic [BUS_SIZE-1:0] words [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_words
      assign words[gi] = in_data[gi*BUS_SIZE +: BUS_SIZE];
    end
  endgenerate

  // The output register can take a new word when empty or when it is being
  // drained this very cycle, giving one word per cycle sustained.
  assign load_en = !out_valid_q || out_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      rr_arbiter #(
        .CHANNELS (CHANNELS)
      ) u_arb (
        .req_i       (in_valid),
        .ptr_i       (ptr_q),
        .grant_o     (pick_oh),
        .grant_idx_o (pick_idx)
      );
      assign sel_oob = 1'b0;
    end else begin : g_sel
      // Only reachable when CHANNELS is not a power of two.
      assign sel_oob  = ({1'b0, selector} >= CH_W);
      assign pick_idx = selector;
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_dec
        assign pick_oh[gi] = (selector == SEL_BITS'(gi));
      end
    end
  endgenerate

  assign in_ready  = pick_oh & {CHANNELS{reset && load_en}};
  assign transfer  = |(in_ready & in_valid);
  // Out-of-range pick_idx never coincides with a transfer, so the word read
  // for it is don't-care.
  assign pick_word = words[pick_idx];
  assign ptr_inc   = {1'b0, pick_idx} + 1'b1;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    ptr_d         = ptr_q;
    sel_error_d   = sel_oob && load_en;
    if (transfer) begin
      out_valid_d   = 1'b1;
      out_data_d    = pick_word;
      out_channel_d = pick_idx;
      ptr_d         = (ptr_inc >= CH_W) ? '0 : ptr_inc[SEL_BITS-1:0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      sel_error_q   <= 1'b0;
      ptr_q         <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      sel_error_q   <= sel_error_d;
      ptr_q         <= ptr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_channel = out_channel_q;
  assign sel_error   = sel_error_q;

endmodule
